// File: rtl/encoder_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
// Shared definitions for the N-to-log2(N) request encoder.
//   MODE_FIXED / MODE_RR : values of the mode input
//   popcount_gt1()       : 1 when more than one bit of a request vector is set
// ---------------------------------------------------------------------------
package encoder_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Callers zero-extend their N-bit vector (N <= 64) to 64 bits.
    // Clearing the lowest set bit leaves a nonzero value only if a second bit
    // was set.
    function automatic logic popcount_gt1(input logic [63:0] v);
        return |(v & (v - 64'd1));
    endfunction

endpackage : encoder_pkg

// File: rtl/encoder_n_to_log_rr_prio_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
// Combinational index selector.
//   req   [N] : request vector
//   base  [W] : round-robin starting point (used when dir = 1)
//   dir       : 0 = highest set index, 1 = lowest set index >= base, with
//               wrap to the lowest set index overall
//   idx   [W] : selected index (0 when nothing is set)
//   found     : at least one request bit is set
// ---------------------------------------------------------------------------
module prio_pick #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    input  logic         dir,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] idx_hi;      // highest set index
    logic [W-1:0] idx_lo;      // lowest set index overall
    logic [W-1:0] idx_from;    // lowest set index >= base
    logic         found_from;

    always_comb begin
        idx_hi     = '0;
        idx_lo     = '0;
        idx_from   = '0;
        found_from = 1'b0;
        // Ascending scan: the last hit is the highest index.
        for (int i = 0; i < N; i++) begin
            if (req[i]) idx_hi = W'(i);
        end
        // Descending scans: the last hit is the lowest qualifying index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx_lo = W'(i);
            if (req[i] && (int'(base) <= i)) begin
                idx_from   = W'(i);
                found_from = 1'b1;
            end
        end
    end

    assign found = |req;
    assign idx   = (dir == 1'b0) ? idx_hi
                 : (found_from   ? idx_from : idx_lo);

endmodule : prio_pick

// File: rtl/encoder_n_to_log_rr.sv
// ---------------------------------------------------------------------------
// encoder_n_to_log_rr
// Registers the index of one active request, chosen by fixed priority
// (highest index) or round-robin, behind a one-deep valid/ready stage.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req   [N]   : request vector
//   mode        : 0 = fixed priority, 1 = round-robin (sampled on load)
//   out_ready   : downstream accepts the current output
//   out_valid   : output fields hold a grant
//   out_idx [W] : granted index
//   out_onehot  : one-hot form of out_idx
//   out_multi   : more than one request was pending at capture
// ---------------------------------------------------------------------------
module encoder_n_to_log_rr
    import encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi
);

    logic         valid_q,  valid_d;
    logic [W-1:0] idx_q,    idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic         multi_q,  multi_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;

    logic [W-1:0] pick_idx;
    logic         pick_found;
    logic         load;

    prio_pick #(.N(N)) u_pick (
        .req   (req),
        .base  (rr_ptr_q),
        .dir   (mode),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Capture whenever the stage is empty or being emptied this cycle.
    assign load = (!valid_q || out_ready) && pick_found;

    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        multi_d  = multi_q;
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            valid_d  = 1'b1;
            idx_d    = pick_idx;
            onehot_d = N'(1) << pick_idx;
            multi_d  = popcount_gt1(64'(req));
            // Wrap at N-1 so non-power-of-2 N never points at an unused code.
            if (mode == MODE_RR) begin
                rr_ptr_d = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            multi_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            multi_q  <= multi_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign out_multi  = multi_q;

endmodule : encoder_n_to_log_rr

// File: tb/tb_encoder_n_to_log_rr.sv
// ---------------------------------------------------------------------------
// tb_encoder_n_to_log_rr
// Directed bench for encoder_n_to_log_rr: an N=8 instance for most steps and
// an N=5 instance for non-power-of-2 round-robin wrap.
// ---------------------------------------------------------------------------
module tb_encoder_n_to_log_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       mode;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic       out_multi;

    logic [4:0] req5;
    logic       mode5;
    logic       ready5;
    logic       valid5;
    logic [2:0] idx5;
    logic [4:0] onehot5;
    logic       multi5;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    encoder_n_to_log_rr #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mode       (mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_multi  (out_multi)
    );

    encoder_n_to_log_rr #(.N(5)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req5),
        .mode       (mode5),
        .out_ready  (ready5),
        .out_valid  (valid5),
        .out_idx    (idx5),
        .out_onehot (onehot5),
        .out_multi  (multi5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one full cycle; outputs are then sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_grant(input string tag, input logic [2:0] idx, input logic multi);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".idx"}, 64'(out_idx), 64'(idx));
        check({tag, ".onehot"}, 64'(out_onehot), 64'(8'd1 << idx));
        check({tag, ".multi"}, 64'(out_multi), 64'(multi));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 8'hFF; mode = 1'b0; out_ready = 1'b0;
        req5 = '0; mode5 = 1'b0; ready5 = 1'b0;

        // 1. Reset held with requests pending
        #1;
        check("rst_t1.valid", 64'(out_valid), 64'd0);
        check("rst_t1.idx", 64'(out_idx), 64'd0);
        check("rst_t1.onehot", 64'(out_onehot), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_hold.valid", 64'(out_valid), 64'd0);
            check("rst_hold.idx", 64'(out_idx), 64'd0);
            check("rst_hold.onehot", 64'(out_onehot), 64'd0);
            check("rst_hold.multi", 64'(out_multi), 64'd0);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        check_grant("rst_rel", 3'd7, 1'b1);

        // 2. Fixed priority
        req = 8'b0010_0100; tick();
        check_grant("fix_25", 3'd5, 1'b1);
        req = 8'b0000_0001; tick();
        check_grant("fix_0", 3'd0, 1'b0);
        req = 8'h00; tick();
        check("fix_drain.valid", 64'(out_valid), 64'd0);

        // 3. Round-robin sweep, pointer starts at 0
        mode = 1'b1; req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_grant("rr_sweep", 3'(k % 8), 1'b1);
        end
        // rr_ptr = 1

        // 4. Backpressure
        req = 8'h00; tick();
        check("bp_drain.valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0; req = 8'b0000_1000; tick();
        check_grant("bp_load", 3'd3, 1'b0);           // rr_ptr = 4
        req = 8'h80;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_grant("bp_hold", 3'd3, 1'b0);
        end
        out_ready = 1'b1; tick();
        check_grant("bp_release", 3'd7, 1'b0);        // rr_ptr = 0

        // 5a. Wrap: grant 6 then only low bits left
        req = 8'b0100_0000; tick();
        check_grant("wrap_a6", 3'd6, 1'b0);           // rr_ptr = 7
        req = 8'b0000_0011; tick();
        check_grant("wrap_a0", 3'd0, 1'b1);           // rr_ptr = 1

        // 5b. Grant 7 from rr_ptr=7, pointer wraps to 0
        req = 8'b0100_0000; tick();
        check_grant("wrap_b6", 3'd6, 1'b0);           // rr_ptr = 7
        req = 8'b1000_0001; tick();
        check_grant("wrap_b7", 3'd7, 1'b1);           // rr_ptr = 0
        tick();
        check_grant("wrap_b0", 3'd0, 1'b1);           // rr_ptr = 1
        mode = 1'b0; tick();
        check_grant("fix_keep_ptr", 3'd7, 1'b1);      // rr_ptr stays 1
        mode = 1'b1; req = 8'hFF; tick();
        check_grant("rr_resume", 3'd1, 1'b1);         // rr_ptr = 2

        // 5c. N=5 wraps at 4
        req = 8'h00;
        req5 = 5'b11111; mode5 = 1'b1; ready5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("n5.valid", 64'(valid5), 64'd1);
            check("n5.idx", 64'(idx5), 64'(k % 5));
            check("n5.onehot", 64'(onehot5), 64'(5'd1 << (k % 5)));
        end
        req5 = '0;
        check("n5_main_drain.valid", 64'(out_valid), 64'd0);

        // 6. Asynchronous reset while holding, rr_ptr = 3
        out_ready = 1'b0; req = 8'b0000_0100; tick();
        check_grant("ar_load", 3'd2, 1'b0);
        req = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("ar_async.valid", 64'(out_valid), 64'd0);
        check("ar_async.idx", 64'(out_idx), 64'd0);
        check("ar_async.onehot", 64'(out_onehot), 64'd0);
        check("ar_async.multi", 64'(out_multi), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        check("ar_idle.valid", 64'(out_valid), 64'd0);
        req = 8'hFF; out_ready = 1'b1; tick();
        check_grant("ar_rr_restart", 3'd0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_encoder_n_to_log_rr
